// File: rtl/memory_pkg.sv
// Shared defaults and word/address types for the memory block.
package memory_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

   typedef logic [ADDR_W_DEF-1:0] addr_t;
   typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/memory_mem_array.sv
// Storage array with a single synchronous write port and a combinational read of the same address.
// Every word is cleared asynchronously by rst.
module mem_array
   import memory_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] rd_word
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              addr_ok;

   // Addresses beyond DEPTH are dropped rather than aliased onto real words.
   assign addr_ok = (32'(addr) < DEPTH);

   always_comb begin
      mem_d = mem_q;
      if (wr_en && addr_ok) begin
         mem_d[addr] = data;
      end
   end

   assign rd_word = addr_ok ? mem_q[addr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/memory.sv
// Single-port memory with registered read data and a valid strobe.
// Define MEM_WR_FWD_EN for write-first forwarding on a same-edge read and write; default is read-first.
module memory
   import memory_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid
);

   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem_array (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .addr    (addr),
      .data    (data),
      .rd_word (rd_word)
   );

   // Read and write share one address, so a simultaneous write is always to the word being read.
   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rd_en;
      if (rd_en) begin
`ifdef MEM_WR_FWD_EN
         rdata_d = wr_en ? data : rd_word;
`else
         rdata_d = rd_word;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;

endmodule

// File: tb/tb_memory.sv
// Directed self-checking bench for memory; honours MEM_WR_FWD_EN for the read-during-write case.
module tb_memory;
   import memory_pkg::*;

   logic  clk;
   logic  rst;
   logic  wr_en;
   addr_t addr;
   data_t data;
   logic  rd_en;
   data_t rdata;
   logic  rvalid;

   int checks = 0;
   int errors = 0;

   memory dut (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .addr   (addr),
      .data   (data),
      .rd_en  (rd_en),
      .rdata  (rdata),
      .rvalid (rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change at the falling edge, one rising edge elapses, then outputs are sampled at the next falling edge.
   task automatic cycle(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic rd);
      wr_en = wr;
      addr  = a;
      data  = d;
      rd_en = rd;
      @(negedge clk);
   endtask

   task automatic check_read(input string tag, input logic [7:0] exp);
      check({tag, "_rdata"}, rdata, exp);
      check({tag, "_rvalid"}, {7'b0, rvalid}, 8'h01);
   endtask

   initial begin
      rst   = 1'b1;
      wr_en = 1'b0;
      addr  = '0;
      data  = '0;
      rd_en = 1'b0;
      #2;
      check("reset_rdata", rdata, 8'h00);
      check("reset_rvalid", {7'b0, rvalid}, 8'h00);

      // Writes and reads while in reset must be ignored.
      @(negedge clk);
      cycle(1'b1, 8'h05, 8'h77, 1'b1);
      check("in_reset_rvalid", {7'b0, rvalid}, 8'h00);
      check("in_reset_rdata", rdata, 8'h00);
      wr_en = 1'b0;
      rd_en = 1'b0;
      rst   = 1'b0;

      // First operation after release takes effect at the first edge.
      cycle(1'b0, 8'h00, 8'h00, 1'b1);
      check_read("rd_00_reset", 8'h00);
      cycle(1'b0, 8'hFF, 8'h00, 1'b1);
      check_read("rd_FF_reset", 8'h00);
      cycle(1'b0, 8'h05, 8'h00, 1'b1);
      check_read("rd_05_ignored_write", 8'h00);
      cycle(1'b0, 8'h00, 8'h00, 1'b0);
      check("idle_rvalid", {7'b0, rvalid}, 8'h00);

      cycle(1'b1, 8'h02, 8'hA5, 1'b0);
      cycle(1'b0, 8'h02, 8'h00, 1'b1);
      check_read("rd_02_A5", 8'hA5);
      cycle(1'b0, 8'h02, 8'h00, 1'b0);
      check("hold_rdata", rdata, 8'hA5);
      check("hold_rvalid", {7'b0, rvalid}, 8'h00);

      // Reset pulse between edges, then wr_en=0 with live addr/data must leave storage alone.
      #2 rst = 1'b1;
      #1;
      check("rst_pulse_rdata", rdata, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h02, 8'hA5, 1'b0);
      cycle(1'b0, 8'h02, 8'hA5, 1'b1);
      check_read("rd_02_no_write", 8'h00);

      cycle(1'b1, 8'hFF, 8'h3C, 1'b0);
      cycle(1'b1, 8'h00, 8'hC3, 1'b0);
      cycle(1'b0, 8'hFF, 8'h00, 1'b1);
      check_read("rd_FF_3C", 8'h3C);
      cycle(1'b0, 8'h00, 8'h00, 1'b1);
      check_read("rd_00_C3", 8'hC3);

      // A write-enable glitch entirely between rising edges has no effect.
      rd_en = 1'b0;
      #2 wr_en = 1'b1; addr = 8'h30; data = 8'h99;
      #2 wr_en = 1'b0;
      @(negedge clk);
      cycle(1'b0, 8'h30, 8'h00, 1'b1);
      check_read("rd_30_glitch", 8'h00);

      cycle(1'b1, 8'h10, 8'h11, 1'b0);
      cycle(1'b1, 8'h10, 8'h22, 1'b1);
`ifdef MEM_WR_FWD_EN
      check_read("rdw_10", 8'h22);
`else
      check_read("rdw_10", 8'h11);
`endif
      cycle(1'b0, 8'h10, 8'h00, 1'b1);
      check_read("rd_10_after", 8'h22);

      cycle(1'b1, 8'h07, 8'h5A, 1'b0);
      cycle(1'b0, 8'h07, 8'h00, 1'b1);
      check_read("rd_07_5A", 8'h5A);
      #2 rst = 1'b1;
      #1;
      check("midrst_rdata", rdata, 8'h00);
      check("midrst_rvalid", {7'b0, rvalid}, 8'h00);
      rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 8'h07, 8'h00, 1'b1);
      check_read("rd_07_after_rst", 8'h00);
      cycle(1'b0, 8'h10, 8'h00, 1'b1);
      check_read("rd_10_after_rst", 8'h00);
      cycle(1'b0, 8'h00, 8'h00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter DATA_W, default 8, data word width in bits.
REQ-003 Parameter DEPTH, default 256 (2**ADDR_W), number of words.
REQ-004 Ports SHALL be, in order:
- clk  input  1  sole clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- wr_en  input  1  write enable
- addr  input  ADDR_W  shared write/read address
- data  input  DATA_W  write data
- rd_en  input  1  read enable
- rdata  output  DATA_W  registered read data
- rvalid  output  1  rdata valid strobe

Function
REQ-005 Storage SHALL be DEPTH words of DATA_W bits, indexed by addr.
REQ-006 A write SHALL occur at a rising clk edge when wr_en=1: mem[addr] <= data.
- wr_en=0: no storage change regardless of addr/data activity.
REQ-007 A read SHALL be captured at a rising clk edge when rd_en=1: rdata <= mem[addr], rvalid <= 1; latency exactly one cycle.
REQ-008 With rd_en=0, rdata SHALL hold its last value and rvalid SHALL be 0 on the following cycle.
REQ-009 wr_en and rd_en SHALL be legal together; same-address behaviour is defined under Configuration, different addresses are independent.
REQ-010 All addresses 0..DEPTH-1 SHALL be accessible, with no wrap-around or aliasing; addr=0xFF is a valid last word.
REQ-011 Inputs are sampled only at rising clk edges; mid-cycle changes to addr, data or wr_en SHALL have no effect.

Reset
REQ-012 rst=1 SHALL immediately, without a clock edge, clear every storage word to 0, rdata to 0 and rvalid to 0.
REQ-013 While rst=1, writes and reads SHALL be ignored.
REQ-014 The first operation after rst deasserts SHALL take effect at the first rising edge with rst=0.
REQ-015 Reset asserted mid-operation SHALL discard any in-flight read; rvalid SHALL read 0 after reset.

Configuration
REQ-016 Macro MEM_WR_FWD_EN SHALL select same-address read-during-write behaviour.
- Defined: rdata returns the new write data (write-first forwarding).
- Undefined: rdata returns the previously stored word (read-first).
REQ-017 Storage contents after the cycle SHALL be identical in both builds.

Structure
REQ-018 Package memory_pkg SHALL hold the ADDR_W, DATA_W and DEPTH defaults and an addr_t/data_t typedef pair.
REQ-019 The storage array with its write port SHALL be a sub-module mem_array.
REQ-020 The read register, rvalid and forwarding mux SHALL reside in memory.

Verification
REQ-021 Reset, then read addr 0x00 and addr 0xFF -> rdata=0x00, rvalid=1 one cycle after each rd_en.
REQ-022 wr_en=1, addr=0x02, data=0xA5 for one edge; then rd_en=1, addr=0x02 -> rdata=0xA5 one cycle later.
REQ-023 Hold addr=0x02, data=0xA5 with wr_en=0 for 4 cycles, then read 0x02 -> 0x00.
REQ-024 Write 0x3C to addr 0xFF and 0xC3 to addr 0x00, then read both -> 0x3C and 0xC3 respectively.
REQ-025 With mem[0x10]=0x11, write 0x22 to 0x10 with rd_en=1 on the same edge -> rdata=0x22 with MEM_WR_FWD_EN, 0x11 without; a later read returns 0x22 in both builds.
REQ-026 Write 0x5A to 0x07, assert rst mid-cycle -> rdata=0 and rvalid=0 at once; a read of 0x07 after release -> 0x00.
